// File: rtl/trivium_session_ctrl.sv
// Session sequencer for a Trivium keystream core: seed load, warm-up, then one byte
// per valid/ready handshake XORed with the next 8 keystream bits (LSB first).
module trivium_session_ctrl #(
    parameter int unsigned WARMUP_CYCLES = 1152,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             seed_valid_i,
    input  logic [7:0]       seed_data_i,
    input  logic             clear_i,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [7:0]       out_data_o,
    input  logic             out_ready_i,
    output logic             core_load_o,
    output logic [7:0]       core_seed_o,
    output logic             core_clear_o,
    output logic             core_step_o,
    input  logic             core_ks_i,
    output logic             keyed_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] byte_count_o
);

    localparam int unsigned WarmW = $clog2(WARMUP_CYCLES + 1);
    localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StWarm, StReady, StGen, StOut} state_e;

    state_e             state_q;
    logic [WarmW-1:0]   warm_cnt_q;
    logic [2:0]         bit_cnt_q;
    logic [7:0]         ks_q;
    logic [7:0]         data_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [7:0]         out_data_q;
    logic               core_load_q;
    logic [7:0]         core_seed_q;
    logic               core_clear_q;
    logic               core_step_q;
    logic               keyed_q;
    logic               busy_q;
    logic [CNT_W-1:0]   byte_count_q;

    // All outputs are registered, so each transition also sets the outputs of the state it enters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            warm_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            ks_q         <= '0;
            data_q       <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            core_load_q  <= 1'b0;
            core_seed_q  <= '0;
            core_clear_q <= 1'b0;
            core_step_q  <= 1'b0;
            keyed_q      <= 1'b0;
            busy_q       <= 1'b0;
            byte_count_q <= '0;
        end else begin
            core_load_q  <= 1'b0;
            core_clear_q <= 1'b0;
            if (clear_i) begin
                state_q      <= StIdle;
                core_clear_q <= 1'b1;
                keyed_q      <= 1'b0;
                out_valid_q  <= 1'b0;
                byte_count_q <= '0;
                in_ready_q   <= 1'b0;
                core_step_q  <= 1'b0;
                busy_q       <= 1'b0;
            end else if (seed_valid_i) begin
                // Rekey from any state drops the in-flight and pending byte.
                state_q      <= StLoad;
                core_seed_q  <= seed_data_i;
                core_load_q  <= 1'b1;
                keyed_q      <= 1'b0;
                out_valid_q  <= 1'b0;
                byte_count_q <= '0;
                in_ready_q   <= 1'b0;
                core_step_q  <= 1'b0;
                busy_q       <= 1'b1;
            end else begin
                unique case (state_q)
                    StLoad: begin
                        state_q     <= StWarm;
                        warm_cnt_q  <= '0;
                        core_step_q <= 1'b1;
                    end
                    StWarm: begin
                        if (warm_cnt_q == WarmLast) begin
                            state_q     <= StReady;
                            core_step_q <= 1'b0;
                            keyed_q     <= 1'b1;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            warm_cnt_q <= warm_cnt_q + WarmW'(1);
                        end
                    end
                    StReady: begin
                        if (in_valid_i) begin
                            state_q     <= StGen;
                            data_q      <= in_data_i;
                            bit_cnt_q   <= '0;
                            in_ready_q  <= 1'b0;
                            core_step_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                    StGen: begin
                        ks_q[bit_cnt_q] <= core_ks_i;
                        bit_cnt_q       <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q     <= StOut;
                            out_data_q  <= data_q ^ {core_ks_i, ks_q[6:0]};
                            out_valid_q <= 1'b1;
                            core_step_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                    StOut: begin
                        if (out_ready_i) begin
                            state_q      <= StReady;
                            out_valid_q  <= 1'b0;
                            byte_count_q <= byte_count_q + CNT_W'(1);
                            in_ready_q   <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign core_load_o  = core_load_q;
    assign core_seed_o  = core_seed_q;
    assign core_clear_o = core_clear_q;
    assign core_step_o  = core_step_q;
    assign keyed_o      = keyed_q;
    assign busy_o       = busy_q;
    assign byte_count_o = byte_count_q;

endmodule

// File: tb/tb_trivium_session_ctrl.sv
// Directed bench for trivium_session_ctrl with a 16-bit LFSR stand-in for the keystream core.
module tb_trivium_session_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        seed_valid = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]  seed_data = 8'h00, in_data = 8'h00;
    logic        in_ready, out_valid, core_load, core_clear, core_step, core_ks, keyed, busy;
    logic [7:0]  out_data, core_seed;
    logic [15:0] byte_count;

    logic        ks_one = 1'b1;
    logic [15:0] lfsr = 16'h0;
    assign core_ks = ks_one ? 1'b1 : lfsr[0];

    trivium_session_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .seed_valid_i(seed_valid), .seed_data_i(seed_data),
        .clear_i(clear), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
        .core_load_o(core_load), .core_seed_o(core_seed), .core_clear_o(core_clear),
        .core_step_o(core_step), .core_ks_i(core_ks), .keyed_o(keyed), .busy_o(busy),
        .byte_count_o(byte_count)
    );

    // Small instance for the counter-wrap boundary.
    logic       w_seed_valid = 1'b0, w_in_valid = 1'b0, w_out_ready = 1'b0;
    logic [7:0] w_in_data = 8'h00;
    logic       w_in_ready, w_out_valid, w_core_load, w_core_clear, w_core_step, w_keyed, w_busy;
    logic [7:0] w_out_data, w_core_seed;
    logic [2:0] w_byte_count;

    trivium_session_ctrl #(.WARMUP_CYCLES(4), .CNT_W(3)) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .seed_valid_i(w_seed_valid), .seed_data_i(8'h5A),
        .clear_i(1'b0), .in_valid_i(w_in_valid), .in_data_i(w_in_data), .in_ready_o(w_in_ready),
        .out_valid_o(w_out_valid), .out_data_o(w_out_data), .out_ready_i(w_out_ready),
        .core_load_o(w_core_load), .core_seed_o(w_core_seed), .core_clear_o(w_core_clear),
        .core_step_o(w_core_step), .core_ks_i(1'b1), .keyed_o(w_keyed), .busy_o(w_busy),
        .byte_count_o(w_byte_count)
    );

    always @(posedge clk) begin
        if (core_clear)     lfsr <= 16'h0;
        else if (core_load) lfsr <= {8'hA5, core_seed};
        else if (core_step) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    int step_cnt = 0, load_cnt = 0, both_cnt = 0;
    always @(posedge clk) begin
        if (core_step) step_cnt++;
        if (core_load) load_cnt++;
        if (core_load && core_step) both_cnt++;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_ks(input logic [7:0] s, input int n);
        logic [15:0] st;
        logic [7:0]  b;
        st = {8'hA5, s};
        for (int i = 0; i < 1152 + 8 * n; i++) st = {st[0] ^ st[2] ^ st[3] ^ st[5], st[15:1]};
        for (int i = 0; i < 8; i++) begin
            b[i] = st[0];
            st = {st[0] ^ st[2] ^ st[3] ^ st[5], st[15:1]};
        end
        return b;
    endfunction

    task automatic do_seed(input logic [7:0] s);
        seed_valid = 1'b1; seed_data = s;
        tick();
        seed_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_keyed(output bit ov_seen);
        int n = 0;
        ov_seen = 1'b0;
        while (!keyed && n < 2000) begin
            tick();
            n++;
            if (out_valid) ov_seen = 1'b1;
        end
        chk("keyed_reached", keyed, 1);
    endtask

    task automatic send_byte(input logic [7:0] d, input int stall,
                             output logic [7:0] res, output int lat);
        int n = 0;
        int s0;
        bit changed = 1'b0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        res = out_data;
        if (stall > 0) begin
            s0 = step_cnt;
            repeat (stall) begin
                tick();
                if (out_data !== res || !out_valid) changed = 1'b1;
            end
            chk("stall_out_stable", changed, 0);
            chk("stall_no_step", step_cnt - s0, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] pt [4];
        logic [7:0] ct [4];
        logic [7:0] exp2 [4];
        logic [7:0] res;
        int lat, s0, l0, n;
        bit ov;

        pt[0] = 8'hDE; pt[1] = 8'hAD; pt[2] = 8'hBE; pt[3] = 8'hEF;
        exp2[0] = 8'h21; exp2[1] = 8'h52; exp2[2] = 8'h41; exp2[3] = 8'h10;

        // 1. Reset and keying
        tick(); tick();
        chk("reset_outputs", {in_ready, out_valid, out_data, core_load, core_seed, core_clear,
                              core_step, keyed, busy, byte_count}, 0);
        rst_n = 1'b1;
        tick();
        do_seed(8'h23);
        chk("load_pulse", core_load, 1);
        chk("load_seed", core_seed, 8'h23);
        chk("load_busy", busy, 1);
        s0 = step_cnt; l0 = load_cnt;
        wait_keyed(ov);
        chk("warm_steps", step_cnt - s0, 1152);
        chk("load_once", load_cnt - l0, 1);
        chk("keyed_in_ready", in_ready, 1);
        chk("keyed_not_busy", busy, 0);

        // 2. ks=1 stub
        for (int i = 0; i < 4; i++) begin
            s0 = step_cnt;
            send_byte(pt[i], 0, res, lat);
            chk("stub_out", res, exp2[i]);
            chk("stub_latency", lat, 8);
            chk("stub_steps", step_cnt - s0, 8);
        end
        chk("stub_count", byte_count, 4);

        // 3. Model core: encrypt then decrypt with the same seed
        ks_one = 1'b0;
        do_clear();
        chk("clear_pulse", core_clear, 1);
        chk("clear_idle", {keyed, in_ready, out_valid, busy, byte_count}, 0);
        do_seed(8'h23);
        wait_keyed(ov);
        for (int i = 0; i < 4; i++) begin
            send_byte(pt[i], 0, res, lat);
            ct[i] = res;
            chk("enc_ref", res, pt[i] ^ ref_ks(8'h23, i));
        end
        do_clear();
        do_seed(8'h23);
        wait_keyed(ov);
        for (int i = 0; i < 4; i++) begin
            send_byte(ct[i], 0, res, lat);
            chk("dec_recover", res, pt[i]);
        end

        // 4. Backpressure
        do_clear();
        do_seed(8'h23);
        wait_keyed(ov);
        send_byte(8'h00, 20, res, lat);
        chk("bp_byte0", res, ref_ks(8'h23, 0));
        send_byte(8'h00, 0, res, lat);
        chk("bp_byte1", res, ref_ks(8'h23, 1));

        // 5. Rekey at GEN bit 3, then clear+seed together
        in_valid = 1'b1; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("gen_stepping", core_step, 1);
        do_seed(8'h23);
        chk("rekey_load", core_load, 1);
        chk("rekey_state", {out_valid, keyed, byte_count, core_step}, 0);
        s0 = step_cnt;
        wait_keyed(ov);
        chk("rekey_no_out", ov, 0);
        chk("rekey_warm_steps", step_cnt - s0, 1152);
        chk("rekey_count", byte_count, 0);
        l0 = load_cnt;
        clear = 1'b1; seed_valid = 1'b1; seed_data = 8'h44;
        tick();
        clear = 1'b0; seed_valid = 1'b0;
        chk("clr_seed_core_clear", core_clear, 1);
        chk("clr_seed_no_load", core_load, 0);
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        chk("clr_seed_idle", {keyed, busy, in_ready, core_step, out_valid}, 0);
        chk("clr_seed_load_cnt", load_cnt - l0, 0);

        // 6. Counter wrap on the small instance, then reset mid-WARM
        w_seed_valid = 1'b1;
        tick();
        w_seed_valid = 1'b0;
        n = 0;
        while (!w_keyed && n < 50) begin
            tick();
            n++;
        end
        chk("w_keyed", w_keyed, 1);
        for (int b = 0; b < 8; b++) begin
            w_in_valid = 1'b1; w_in_data = 8'(b);
            tick();
            w_in_valid = 1'b0;
            n = 0;
            while (!w_out_valid && n < 30) begin
                tick();
                n++;
            end
            if (b == 0) chk("w_out_data", w_out_data, 8'hFF);
            w_out_ready = 1'b1;
            tick();
            w_out_ready = 1'b0;
            if (b == 6) chk("w_count_max", w_byte_count, 7);
        end
        chk("w_count_wrap", w_byte_count, 0);

        do_seed(8'h23);
        repeat (10) tick();
        chk("midwarm_step", core_step, 1);
        rst_n = 1'b0;
        tick();
        chk("midwarm_reset", {in_ready, out_valid, out_data, core_load, core_seed, core_clear,
                              core_step, keyed, busy, byte_count}, 0);
        rst_n = 1'b1;
        tick();
        chk("load_step_exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
